// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: one add/shift per clock over a ripple-carry adder chain.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned CW = $clog2(WIDTH);
`ifdef MULT_SIGNED_EN
  localparam int unsigned AW = WIDTH + 1;
`else
  localparam int unsigned AW = WIDTH;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      count_q, count_d;

  logic [WIDTH-1:0]   acc;
  logic               last;
  logic [AW-1:0]      add_a, add_b, add_s;
  logic [AW-1:0]      cy;
  logic [2*WIDTH-1:0] iter_product;

  assign acc  = product_q[2*WIDTH-1:WIDTH];
  assign last = (count_q == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  logic sub;
  // Final multiplier bit carries negative weight: subtract via inverted mcand and cin=1.
  assign sub   = last & product_q[0];
  assign add_a = {acc[WIDTH-1], acc};
  assign add_b = {mcand_q[WIDTH-1], mcand_q} ^ {AW{sub}};
  assign cy[0] = sub;
  assign iter_product = product_q[0] ? {add_s, product_q[WIDTH-1:1]}
                                     : {product_q[2*WIDTH-1], product_q[2*WIDTH-1:1]};
`else
  logic cout;
  assign add_a = acc;
  assign add_b = mcand_q;
  assign cy[0] = 1'b0;
  assign cout  = (add_a[AW-1] & add_b[AW-1]) | (cy[AW-1] & (add_a[AW-1] ^ add_b[AW-1]));
  assign iter_product = product_q[0] ? {cout, add_s, product_q[WIDTH-1:1]}
                                     : {1'b0, product_q[2*WIDTH-1:1]};
`endif

  // Ripple chain of full-adder cells.
  for (genvar i = 0; i < AW; i++) begin : g_fa
    assign add_s[i] = add_a[i] ^ add_b[i] ^ cy[i];
    if (i < AW - 1) begin : g_cy
      assign cy[i+1] = (add_a[i] & add_b[i]) | (cy[i] & (add_a[i] ^ add_b[i]));
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          mcand_d   = multiplicand;
          product_d = {{WIDTH{1'b0}}, multiplier};
          count_d   = '0;
        end
      end
      StRun: begin
        product_d = iter_product;
        count_d   = count_q + CW'(1);
        if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=8): vector table, hand sequences, random ops.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  multiplicand, multiplier;
  logic        ready, busy, done;
  logic [15:0] product;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_add_mult #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int x, y;
`ifdef MULT_SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(b));
`else
    x = int'(a);
    y = int'(b);
`endif
    return 16'(x * y);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 50) begin
      step();
      k++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  // One full operation with start pulsed for a single cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string tag);
    int lat;
    wait_ready();
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    step();
    start = 1'b0;
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_product"}, 32'(product), 32'(exp));
    step();
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    vec_t vecs[$];
    int lat, t, first, second, seen;

`ifdef MULT_SIGNED_EN
    vecs.push_back('{8'hFF, 8'h02, 16'hFFFE});
    vecs.push_back('{8'h80, 8'h80, 16'h4000});
    vecs.push_back('{8'h80, 8'h7F, 16'hC080});
    vecs.push_back('{8'h7F, 8'h7F, 16'h3F01});
    vecs.push_back('{8'hFF, 8'hFF, 16'h0001});
    vecs.push_back('{8'h03, 8'hFB, 16'hFFF1});
`else
    vecs.push_back('{8'h0F, 8'h0F, 16'h00E1});
    vecs.push_back('{8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{8'h00, 8'hAB, 16'h0000});
    vecs.push_back('{8'h80, 8'h02, 16'h0100});
    vecs.push_back('{8'h7F, 8'h7F, 16'h3F01});
    vecs.push_back('{8'h01, 8'hFF, 16'h00FF});
    vecs.push_back('{8'hFF, 8'h80, 16'h7F80});
`endif

    reset = 1'b1;
    start = 1'b0;
    multiplicand = 8'h00;
    multiplier = 8'h00;
    step();
    step();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start held high with operands churning while busy.
    wait_ready();
    start = 1'b1;
    multiplicand = 8'h0F;
    multiplier = 8'h0F;
    step();
    lat = 0;
    while (!done && lat < 40) begin
      multiplicand = 8'($urandom);
      multiplier = 8'($urandom);
      step();
      lat++;
    end
    chk("hold_latency", 32'(lat), 32'd8);
    chk("hold_product", 32'(product), 32'(model(8'h0F, 8'h0F)));
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    step();
    chk("hold_ready", 32'(ready), 32'd1);
    chk("hold_ready_product", 32'(product), 32'(model(8'h0F, 8'h0F)));
    multiplicand = 8'h05;
    multiplier = 8'h06;
    step();
    chk("hold_accept", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("hold_second_product", 32'(product), 32'(model(8'h05, 8'h06)));

    // Back-to-back with start tied high.
    wait_ready();
    start = 1'b1;
    multiplicand = 8'h80;
    multiplier = 8'h02;
    step();
    multiplicand = 8'h7F;
    multiplier = 8'h7F;
    t = 0;
    first = -1;
    second = -1;
    while (t < 40 && second < 0) begin
      step();
      t++;
      if (done) begin
        if (first < 0) begin
          first = t;
          chk("b2b_first", 32'(product), 32'(model(8'h80, 8'h02)));
        end else begin
          second = t;
          start = 1'b0;
          chk("b2b_second", 32'(product), 32'(model(8'h7F, 8'h7F)));
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", 32'(first), 32'd8);
    chk("b2b_spacing", 32'(second - first), 32'd10);

    // Reset during the third RUN cycle aborts the op.
    wait_ready();
    start = 1'b1;
    multiplicand = 8'h12;
    multiplier = 8'h34;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(8'h03, 8'h05, model(8'h03, 8'h05), "after_abort");

    for (int r = 0; r < 25; r++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(a, b, model(a, b), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
